// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants for the 4x4 convolution window feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;
    localparam int c_LEN_IN_DEF = 8;
    localparam int c_WIN        = 4;
    localparam int c_ST_W       = 2;

    localparam logic [c_ST_W-1:0] c_LOAD_K = 2'd0;
    localparam logic [c_ST_W-1:0] c_STREAM = 2'd1;
    localparam logic [c_ST_W-1:0] c_DRAIN  = 2'd2;

    // Flat slice index of window/kernel element (r, c).
    function automatic int win_idx(input int r, input int c);
        return c_WIN * r + c;
    endfunction
endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
// Module      : line_buffer
// Description : DEPTH-entry delay line that advances only when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer
    import conv_pkg::*;
#(
    parameter int LEN_IN = c_LEN_IN_DEF,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [LEN_IN-1:0] i_din,
    output logic [LEN_IN-1:0] o_dout
);

    logic [LEN_IN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_window_feeder.sv
// ============================================================================
// Module      : conv_window_feeder
// Description : Loads a 4x4 kernel, then streams raster pixels into 4x4 windows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int LEN_IN = c_LEN_IN_DEF,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            k_valid,
    input  logic signed [LEN_IN-1:0]        k_data,
    output logic                            k_ready,
    input  logic                            pix_valid,
    input  logic signed [LEN_IN-1:0]        pix_data,
    output logic                            pix_ready,
    output logic [c_WIN*c_WIN*LEN_IN-1:0]   win_data,
    output logic [c_WIN*c_WIN*LEN_IN-1:0]   kernel,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic                            frame_done
);

    localparam int c_WIN_BITS = c_WIN * c_WIN * LEN_IN;
    localparam int c_COL_W    = $clog2(IMG_W);
    localparam int c_ROW_W    = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_WIN  = c_COL_W'(c_WIN - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_WIN  = c_ROW_W'(c_WIN - 1);

    logic [c_ST_W-1:0]     r_state;
    logic [3:0]            r_k_cnt;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_WIN_BITS-1:0] r_kernel;
    logic [c_WIN_BITS-1:0] r_win_sr;
    logic [c_WIN_BITS-1:0] r_win_data;
    logic                  r_win_valid;
    logic                  r_frame_done;

    logic                  w_k_acc;
    logic                  w_pix_acc;
    logic                  w_win_hand;
    logic                  w_win_load;
    logic                  w_last_pix;
    logic                  w_frame_end;
    logic [c_WIN_BITS-1:0] w_win_nxt;
    logic [LEN_IN-1:0]     w_lb_tap [c_WIN];

    assign k_ready     = (r_state == c_LOAD_K);
    assign pix_ready   = (r_state == c_STREAM) && (!r_win_valid || win_ready);
    assign w_k_acc     = k_valid && k_ready;
    assign w_pix_acc   = pix_valid && pix_ready;
    assign w_win_hand  = r_win_valid && win_ready;
    assign w_last_pix  = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    assign w_win_load  = w_pix_acc && (r_col >= c_COL_WIN) && (r_row >= c_ROW_WIN);
    assign w_frame_end = (r_state == c_DRAIN) && w_win_hand;

    // Tap k is the pixel from k rows earlier; tap 0 is the live input.
    assign w_lb_tap[0] = pix_data;

    generate
        for (genvar g = 0; g < c_WIN - 1; g++) begin : g_lb
            line_buffer #(
                .LEN_IN (LEN_IN),
                .DEPTH  (IMG_W)
            ) u_line_buffer (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_pix_acc),
                .i_clr  (w_frame_end),
                .i_din  (w_lb_tap[g]),
                .o_dout (w_lb_tap[g+1])
            );
        end
    endgenerate

    // Window shifts left; the new column enters at c=3 with the oldest row at r=0.
    always_comb begin
        w_win_nxt = '0;
        for (int r = 0; r < c_WIN; r++) begin
            for (int c = 0; c < c_WIN; c++) begin
                if (c == c_WIN - 1)
                    w_win_nxt[LEN_IN*win_idx(r, c) +: LEN_IN] = w_lb_tap[c_WIN-1-r];
                else
                    w_win_nxt[LEN_IN*win_idx(r, c) +: LEN_IN] =
                        r_win_sr[LEN_IN*win_idx(r, c+1) +: LEN_IN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_LOAD_K;
            r_k_cnt  <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_kernel <= '0;
        end else begin
            case (r_state)
                c_LOAD_K: begin
                    if (w_k_acc) begin
                        r_kernel[LEN_IN*int'(r_k_cnt) +: LEN_IN] <= k_data;
                        if (r_k_cnt == 4'd15) begin
                            r_k_cnt <= '0;
                            r_state <= c_STREAM;
                        end else begin
                            r_k_cnt <= r_k_cnt + 4'd1;
                        end
                    end
                end
                c_STREAM: begin
                    if (w_pix_acc) begin
                        if (w_last_pix) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= c_DRAIN;
                        end else if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_win_hand) r_state <= c_STREAM;
                end
                default: r_state <= c_LOAD_K;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_sr     <= '0;
            r_win_data   <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_pix_acc)
                r_win_sr <= w_win_nxt;
            else if (w_frame_end)
                r_win_sr <= '0;
            if (w_win_load) begin
                r_win_data  <= w_win_nxt;
                r_win_valid <= 1'b1;
            end else if (w_win_hand) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign kernel     = r_kernel;
    assign win_data   = r_win_data;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
// ============================================================================
// Module      : tb_conv_window_feeder
// Description : Drives a 4x4 and a 5x4 feeder against a frame-level window model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_feeder;

    localparam int IMG_H = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         k_valid   [2];
    logic [7:0]   k_data    [2];
    logic         k_ready   [2];
    logic         pix_valid [2];
    logic [7:0]   pix_data  [2];
    logic         pix_ready [2];
    logic [127:0] win_data  [2];
    logic [127:0] kernel    [2];
    logic         win_valid [2];
    logic         win_ready [2];
    logic         frame_done[2];

    int errors = 0;
    int checks = 0;

    // stimulus controls
    logic [7:0] stim_k [2][16];
    logic [7:0] stim_p [2][20];
    bit         rdy_force [2];
    bit         rdy_val   [2];
    bit         rdy_rand  [2];

    // behavioural model state
    logic [7:0]   mk   [2][16];
    logic [7:0]   fr   [2][4][5];
    int           kacc [2];
    int           pcnt [2];
    int           wcnt [2];
    int           hand_cnt [2];
    int           fd_cnt   [2];
    bit           pend    [2];
    bit           drain   [2];
    bit           fd_pend [2];
    logic [127:0] exp_win [2];
    logic [127:0] got_win [2][4];
    logic [127:0] mod_win [2][4];

    always #5 clk = ~clk;

    conv_window_feeder #(.LEN_IN(8), .IMG_W(4), .IMG_H(IMG_H)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .k_valid(k_valid[0]), .k_data(k_data[0]), .k_ready(k_ready[0]),
        .pix_valid(pix_valid[0]), .pix_data(pix_data[0]), .pix_ready(pix_ready[0]),
        .win_data(win_data[0]), .kernel(kernel[0]), .win_valid(win_valid[0]),
        .win_ready(win_ready[0]), .frame_done(frame_done[0])
    );

    conv_window_feeder #(.LEN_IN(8), .IMG_W(5), .IMG_H(IMG_H)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .k_valid(k_valid[1]), .k_data(k_data[1]), .k_ready(k_ready[1]),
        .pix_valid(pix_valid[1]), .pix_data(pix_data[1]), .pix_ready(pix_ready[1]),
        .win_data(win_data[1]), .kernel(kernel[1]), .win_valid(win_valid[1]),
        .win_ready(win_ready[1]), .frame_done(frame_done[1])
    );

    function automatic int img_w(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input int d, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // One model step per DUT: check outputs, then apply this cycle's handshakes.
    task automatic mon_step(input int d);
        logic [127:0] ek;
        logic         exp_pr;
        int           w, r, c;
        w = img_w(d);
        if (!rst_n) begin
            chk("rst_win_valid",  d, 128'(win_valid[d]),  128'(0));
            chk("rst_frame_done", d, 128'(frame_done[d]), 128'(0));
            chk("rst_pix_ready",  d, 128'(pix_ready[d]),  128'(0));
            chk("rst_k_ready",    d, 128'(k_ready[d]),    128'(1));
            chk("rst_win_data",   d, win_data[d],         128'(0));
            chk("rst_kernel",     d, kernel[d],           128'(0));
            kacc[d] = 0; pcnt[d] = 0; wcnt[d] = 0;
            pend[d] = 0; drain[d] = 0; fd_pend[d] = 0;
            return;
        end
        ek = '0;
        for (int i = 0; i < 16; i++)
            if (i < kacc[d]) ek[8*i +: 8] = mk[d][i];
        chk("kernel",     d, kernel[d],               ek);
        chk("k_ready",    d, 128'(k_ready[d]),        128'(kacc[d] < 16));
        chk("win_valid",  d, 128'(win_valid[d]),      128'(pend[d]));
        if (pend[d]) chk("win_data", d, win_data[d], exp_win[d]);
        chk("frame_done", d, 128'(frame_done[d]),     128'(fd_pend[d]));
        if (frame_done[d]) fd_cnt[d]++;
        fd_pend[d] = 0;
        exp_pr = (kacc[d] == 16) && !drain[d] && (!pend[d] || win_ready[d]);
        chk("pix_ready",  d, 128'(pix_ready[d]),      128'(exp_pr));

        if (pend[d] && win_ready[d]) begin
            if (wcnt[d] < 4) begin
                got_win[d][wcnt[d]] = win_data[d];
                mod_win[d][wcnt[d]] = exp_win[d];
            end
            wcnt[d]++;
            hand_cnt[d]++;
            pend[d] = 0;
            if (drain[d]) begin
                drain[d] = 0;
                fd_pend[d] = 1;
                wcnt[d] = 0;
            end
        end
        if (k_valid[d] && kacc[d] < 16) begin
            mk[d][kacc[d]] = k_data[d];
            kacc[d]++;
        end
        if (pix_valid[d] && exp_pr) begin
            r = pcnt[d] / w;
            c = pcnt[d] % w;
            fr[d][r][c] = pix_data[d];
            if (r >= 3 && c >= 3) begin
                chk("win_slot_free", d, 128'(pend[d]), 128'(0));
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        exp_win[d][8*(4*i+j) +: 8] = fr[d][r-3+i][c-3+j];
                pend[d] = 1;
            end
            pcnt[d]++;
            if (pcnt[d] == w * IMG_H) begin
                pcnt[d] = 0;
                drain[d] = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    initial begin
        for (int d = 0; d < 2; d++) win_ready[d] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++)
                win_ready[d] = rdy_force[d] ? rdy_val[d] :
                               (rdy_rand[d] ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    task automatic send_kernel(input int d, input bit rnd);
        int i = 0;
        int guard = 0;
        while (i < 16 && guard < 500) begin
            k_valid[d] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            k_data[d]  = stim_k[d][i];
            @(negedge clk);
            if (k_valid[d] && k_ready[d]) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        k_valid[d] = 1'b0;
        chk("kernel_load_done", d, 128'(i), 128'(16));
    endtask

    task automatic send_pixels(input int d, input int n, input bit rnd);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000) begin
            pix_valid[d] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_data[d]  = stim_p[d][i];
            @(negedge clk);
            if (pix_valid[d] && pix_ready[d]) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        pix_valid[d] = 1'b0;
        chk("pix_send_done", d, 128'(i), 128'(n));
    endtask

    task automatic wait_fd(input int d);
        int n = 0;
        int f0 = fd_cnt[d];
        while (fd_cnt[d] == f0 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("frame_done_seen", d, 128'(fd_cnt[d] - f0), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frames(input int d, input int nf);
        rdy_rand[d] = 1'b1;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < 20; i++) stim_p[d][i] = 8'($urandom);
            send_pixels(d, img_w(d) * IMG_H, 1'b1);
            wait_fd(d);
        end
        rdy_rand[d] = 1'b0;
    endtask

    task automatic frame_4x4_lit(input string tag, input logic [127:0] lit);
        int h0;
        for (int i = 0; i < 16; i++) stim_p[0][i] = 8'(i + 1);
        h0 = hand_cnt[0];
        send_pixels(0, 16, 1'b0);
        wait_fd(0);
        chk({tag, "_win_count"},    0, 128'(hand_cnt[0] - h0), 128'(1));
        chk({tag, "_window"},       0, got_win[0][0], lit);
        chk({tag, "_model_window"}, 0, mod_win[0][0], lit);
    endtask

    initial begin
        logic [127:0] lit;
        logic [127:0] cap;
        int           h0;
        int           n;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            k_valid[d] = 0; k_data[d] = 0; pix_valid[d] = 0; pix_data[d] = 0;
            rdy_force[d] = 0; rdy_val[d] = 0; rdy_rand[d] = 0;
            hand_cnt[d] = 0; fd_cnt[d] = 0;
        end
        lit = '0;
        for (int i = 0; i < 16; i++) begin
            stim_k[0][i] = 8'(i + 1);
            stim_k[1][i] = 8'($urandom);
            lit[8*i +: 8] = 8'(i + 1);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 4x4 image, kernel 1..16, pixels 1..16
        send_kernel(0, 1'b0);
        chk("t1_kernel", 0, kernel[0], lit);
        frame_4x4_lit("t1", lit);

        // 5x4 image, pixels 0..19
        send_kernel(1, 1'b1);
        for (int i = 0; i < 20; i++) stim_p[1][i] = 8'(i);
        h0 = hand_cnt[1];
        send_pixels(1, 20, 1'b0);
        wait_fd(1);
        chk("t2_win_count", 1, 128'(hand_cnt[1] - h0), 128'(2));
        chk("t2_row0",       1, 128'(got_win[1][1][31:0]),   128'(32'h04030201));
        chk("t2_row3",       1, 128'(got_win[1][1][127:96]), 128'(32'h13121110));
        chk("t2_model_row0", 1, 128'(mod_win[1][1][31:0]),   128'(32'h04030201));

        // back-pressure: hold win_ready low while the first window is pending
        for (int i = 0; i < 20; i++) stim_p[1][i] = 8'($urandom);
        rdy_force[1] = 1'b1;
        rdy_val[1]   = 1'b0;
        fork
            send_pixels(1, 20, 1'b0);
        join_none
        n = 0;
        while (!win_valid[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_win_pending", 1, 128'(win_valid[1]), 128'(1));
        cap = win_data[1];
        h0  = hand_cnt[1];
        repeat (10) begin
            @(negedge clk);
            chk("t3_pix_ready_stall", 1, 128'(pix_ready[1]), 128'(0));
            chk("t3_win_stable",      1, win_data[1], cap);
        end
        @(posedge clk);
        #1 rdy_val[1] = 1'b1;
        @(negedge clk);
        #2;
        chk("t3_released", 1, 128'(hand_cnt[1] - h0), 128'(1));
        @(posedge clk);
        #1 rdy_force[1] = 1'b0;
        wait fork;
        wait_fd(1);

        // kernel words offered while streaming are ignored
        k_valid[0] = 1'b1;
        k_data[0]  = 8'h7F;
        repeat (4) begin
            @(negedge clk);
            chk("t4_k_ready", 0, 128'(k_ready[0]), 128'(0));
            chk("t4_kernel",  0, kernel[0], lit);
        end
        @(posedge clk);
        #1 k_valid[0] = 1'b0;

        fork
            rand_frames(0, 3);
            rand_frames(1, 3);
        join

        // reset mid-frame, then reload and repeat the 4x4 frame
        for (int i = 0; i < 16; i++) stim_p[0][i] = 8'(i + 1);
        send_pixels(0, 7, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("t5_rst_kernel",    0, kernel[0],   128'(0));
        chk("t5_rst_win_data",  0, win_data[0], 128'(0));
        chk("t5_rst_k_ready",   0, 128'(k_ready[0]),   128'(1));
        chk("t5_rst_win_valid", 0, 128'(win_valid[0]), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_kernel(0, 1'b0);
        chk("t5_kernel", 0, kernel[0], lit);
        frame_4x4_lit("t5", lit);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
